// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller: op encoding,
// FSM state type and op-class helpers.
package md_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } md_state_e;

    // Multi-cycle ops that occupy the unit.
    function automatic logic is_long(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_short(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_md(input logic [OP_W-1:0] op);
        return is_long(op) | is_short(op);
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// Sequences EX-stage HI/LO instructions onto the multiply/divide unit and stalls the pipe while it is occupied.
// Optional stall counter output enabled by defining MD_STALL_CNT_EN.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned DATA_W = 32
`ifdef MD_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [DATA_W-1:0] ex_a,
    input  logic [DATA_W-1:0] ex_b,
    input  logic              flush,
    input  logic              md_busy,
    output logic              md_start,
    output logic [OP_W-1:0]   md_op,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    output logic              stall,
    output logic              ctrl_busy
`ifdef MD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    md_state_e         state, state_nxt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              idle;
    logic              acc;
    logic              launch;

    assign idle      = (state == ST_IDLE);
    assign stall     = ex_valid & is_md(ex_op) & (~idle | md_busy);
    assign ctrl_busy = ~idle | md_busy;
    assign acc       = ex_valid & ~flush & ~stall;
    assign launch    = idle & acc & is_long(ex_op);

    // Next state and unit-facing operand/op muxing.
    always_comb begin
        state_nxt = state;
        md_op     = OP_NONE;
        md_a      = ex_a;
        md_b      = ex_b;
        unique case (state)
            ST_IDLE: begin
                if (launch) state_nxt = ST_ISSUE;
                if (ex_valid & is_short(ex_op) & ~flush) md_op = ex_op;
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                md_op     = op_q;
                md_a      = a_q;
                md_b      = b_q;
            end
            ST_WAIT: begin
                if (!md_busy) state_nxt = ST_IDLE;
                md_op = op_q;
                md_a  = a_q;
                md_b  = b_q;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            md_start <= 1'b0;
            op_q     <= OP_NONE;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state    <= state_nxt;
            md_start <= (state_nxt == ST_ISSUE);
            if (launch) begin
                op_q <= ex_op;
                a_q  <= ex_a;
                b_q  <= ex_b;
            end
        end
    end

`ifdef MD_STALL_CNT_EN
    // Free-running count of frozen pipeline cycles; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)      stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif

endmodule
